// File: rtl/imm_ext_pipe_pkg.sv
// Shared types for the immediate generator: format enum, RV32/64 opcodes and opcode decode.
package imm_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned OPC_W   = 7;

    typedef enum logic [2:0] {
        IMM_I    = 3'd0,
        IMM_S    = 3'd1,
        IMM_B    = 3'd2,
        IMM_J    = 3'd3,
        IMM_U    = 3'd4,
        IMM_RSVD = 3'd7
    } imm_src_e;

    localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OP_IMM    = 7'b0010011;
    localparam logic [OPC_W-1:0] OP_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OP_SYSTEM = 7'b1110011;
    localparam logic [OPC_W-1:0] OP_R      = 7'b0110011;
    localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OP_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OP_AUIPC  = 7'b0010111;

    // R-type carries no immediate; it maps to I so the datapath sees a defined, legal value.
    function automatic imm_src_e opcode_to_imm_src(input logic [OPC_W-1:0] op);
        imm_src_e src;
        case (op)
            OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM, OP_R: src = IMM_I;
            OP_STORE:                                  src = IMM_S;
            OP_BRANCH:                                 src = IMM_B;
            OP_JAL:                                    src = IMM_J;
            OP_LUI, OP_AUIPC:                          src = IMM_U;
            default:                                   src = IMM_RSVD;
        endcase
        return src;
    endfunction

endpackage

// File: rtl/imm_format.sv
// Combinational immediate formatter: builds the 32-bit I/S/B/J/U immediate and sign-extends it to XLEN.
// IMM_ILLEGAL_CHECK_EN adds the illegal_o port; otherwise unknown formats fall back to I.
module imm_format
    import imm_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [INSTR_W-1:7] instr_i,
    input  imm_src_e           src_i,
    output logic [XLEN-1:0]    imm_o
`ifdef IMM_ILLEGAL_CHECK_EN
    ,
    output logic               illegal_o
`endif
);

    logic [INSTR_W-1:0] imm32;
    logic [INSTR_W-1:0] imm_i_fmt;

    assign imm_i_fmt = {{20{instr_i[31]}}, instr_i[31:20]};

    always_comb begin
        imm32 = imm_i_fmt;
`ifdef IMM_ILLEGAL_CHECK_EN
        illegal_o = 1'b0;
`endif
        case (src_i)
            IMM_I: imm32 = imm_i_fmt;
            IMM_S: imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            IMM_B: imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                            instr_i[11:8], 1'b0};
            IMM_J: imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                            instr_i[30:21], 1'b0};
            IMM_U: imm32 = {instr_i[31:12], 12'b0};
            default: begin
`ifdef IMM_ILLEGAL_CHECK_EN
                imm32     = '0;
                illegal_o = 1'b1;
`else
                imm32     = imm_i_fmt;
`endif
            end
        endcase
    end

    assign imm_o = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_ext_pipe.sv
// Registered immediate generator with a 1- or 2-stage valid/ready pipeline feeding the ALU-source mux.
// IMM_ILLEGAL_CHECK_EN enables the imm_illegal flag; without it imm_illegal is tied low.
module imm_ext_pipe
    import imm_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned STAGES      = 1,
    parameter bit          AUTO_DECODE = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instr,
    input  logic [2:0]         imm_src,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    imm_ext,
    output logic               imm_illegal
);

    if (!(XLEN == 32 || XLEN == 64)) begin : g_bad_xlen
        $error("imm_ext_pipe: XLEN must be 32 or 64");
    end
    if (!(STAGES == 1 || STAGES == 2)) begin : g_bad_stages
        $error("imm_ext_pipe: STAGES must be 1 or 2");
    end

    imm_src_e        src_sel_c;
    logic [XLEN-1:0] fmt_imm_c;
    logic            stage_ready_c [STAGES];
    logic            valid_q       [STAGES];
    logic [XLEN-1:0] data_q        [STAGES];

    always_comb begin
        src_sel_c = AUTO_DECODE ? opcode_to_imm_src(instr[OPC_W-1:0]) : imm_src_e'(imm_src);
    end

    // Ready ripples back from the consumer: a stage loads if it, or anything below it, has room.
    always_comb begin
        logic rdy;
        rdy = out_ready;
        for (int s = int'(STAGES) - 1; s >= 0; s--) begin
            rdy              = rdy || !valid_q[s];
            stage_ready_c[s] = rdy;
        end
    end

    assign in_ready = stage_ready_c[0];

`ifdef IMM_ILLEGAL_CHECK_EN
    logic fmt_ill_c;
    logic ill_q [STAGES];

    imm_format #(.XLEN(XLEN)) u_fmt (
        .instr_i   (instr[INSTR_W-1:7]),
        .src_i     (src_sel_c),
        .imm_o     (fmt_imm_c),
        .illegal_o (fmt_ill_c)
    );
`else
    imm_format #(.XLEN(XLEN)) u_fmt (
        .instr_i (instr[INSTR_W-1:7]),
        .src_i   (src_sel_c),
        .imm_o   (fmt_imm_c)
    );
`endif

    for (genvar s = 0; s < int'(STAGES); s++) begin : g_stage
        logic            up_valid;
        logic [XLEN-1:0] up_data;
        logic            valid_d;
        logic [XLEN-1:0] data_d;

        if (s == 0) begin : g_head
            assign up_valid = in_valid;
            assign up_data  = fmt_imm_c;
        end else begin : g_body
            assign up_valid = valid_q[s-1];
            assign up_data  = data_q[s-1];
        end

        always_comb begin
            valid_d = valid_q[s];
            data_d  = data_q[s];
            if (stage_ready_c[s]) begin
                valid_d = up_valid;
                if (up_valid) begin
                    data_d = up_data;
                end
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                valid_q[s] <= 1'b0;
                data_q[s]  <= '0;
            end else begin
                valid_q[s] <= valid_d;
                data_q[s]  <= data_d;
            end
        end

`ifdef IMM_ILLEGAL_CHECK_EN
        logic up_ill;
        logic ill_d;

        if (s == 0) begin : g_ill_head
            assign up_ill = fmt_ill_c;
        end else begin : g_ill_body
            assign up_ill = ill_q[s-1];
        end

        // The flag rides alongside its data word.
        always_comb begin
            ill_d = ill_q[s];
            if (stage_ready_c[s] && up_valid) begin
                ill_d = up_ill;
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                ill_q[s] <= 1'b0;
            end else begin
                ill_q[s] <= ill_d;
            end
        end
`endif
    end

    assign out_valid = valid_q[STAGES-1];
    assign imm_ext   = data_q[STAGES-1];

`ifdef IMM_ILLEGAL_CHECK_EN
    assign imm_illegal = ill_q[STAGES-1];
`else
    assign imm_illegal = 1'b0;
`endif

endmodule
